retry_scheduler: RTL and testbench

RETRY_SCHEDULER -- requirements
Module: retry_scheduler

---
 rtl/retry_pkg.sv | 13 +
 rtl/retry_id_pool.sv | 53 +++++
 rtl/retry_scheduler.sv | 129 ++++++++++++
 tb/tb_retry_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retry_pkg.sv
// Shared sizing helpers for the retry scheduler and its ID pool.
package retry_pkg;

  // Retry counters must hold every value from 0 up to and including max_retries.
  function automatic int unsigned count_width(input int unsigned max_retries);
    return $clog2(max_retries + 1);
  endfunction

  function automatic int unsigned id_slots(input int unsigned id_size);
    return 1 << id_size;
  endfunction

endpackage

// File: rtl/retry_id_pool.sv
// Allocation bitmap with lowest-free priority encoder and registered occupancy count.
module retry_id_pool
  import retry_pkg::*;
#(
  parameter int IdSize = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc,
  input  logic [IdSize-1:0]          alloc_id,
  input  logic [2**IdSize-1:0]       free_mask,
  output logic [IdSize-1:0]          lowest_free,
  output logic                       any_free,
  output logic [IdSize:0]            in_flight
);

  localparam int Slots = id_slots(IdSize);
  localparam int CntW  = IdSize + 1;

  logic [Slots-1:0] allocated;
  logic [Slots-1:0] next_alloc;
  logic [CntW-1:0]  next_count;

  // Frees only act on IDs that are allocated before the edge, so a late done for a
  // free ID can never cancel an allocation landing on the same edge.
  always_comb begin
    next_alloc = allocated & ~(free_mask & allocated);
    if (alloc) next_alloc[alloc_id] = 1'b1;
    next_count = '0;
    for (int i = 0; i < Slots; i++) begin
      next_count = next_count + CntW'(next_alloc[i]);
    end
  end

  always_comb begin
    lowest_free = '0;
    for (int i = Slots - 1; i >= 0; i--) begin
      if (!allocated[i]) lowest_free = IdSize'(i);
    end
    any_free = ~&allocated;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      allocated <= '0;
      in_flight <= '0;
    end else begin
      allocated <= next_alloc;
      in_flight <= next_count;
    end
  end

endmodule

// File: rtl/retry_scheduler.sv
// Issues new operations under an ID, replays them on retry request, aborts after MaxRetries.
// Handshakes: a transfer happens on a cycle where valid and ready are both high at the edge.
module retry_scheduler
  import retry_pkg::*;
#(
  parameter type DataType   = logic,
  parameter int  IDSize     = 2,
  parameter int  MaxRetries = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic [IDSize-1:0] retry_id_i,
  input  logic              retry_valid_i,
  output logic              retry_ready_o,
  input  logic [IDSize-1:0] done_id_i,
  input  logic              done_valid_i,
  output logic [IDSize-1:0] abort_id_o,
  output logic              abort_valid_o,
  output logic [IDSize:0]   in_flight_o
);

  localparam int Slots = id_slots(IDSize);
  localparam int CntW  = count_width(MaxRetries);

  typedef logic [IDSize-1:0] id_t;
  typedef logic [CntW-1:0]   cnt_t;

  localparam cnt_t CntMax = cnt_t'(MaxRetries);

  id_t              lowest_free;
  logic             any_free;
  logic             exhausted;
  logic             alloc_fire;
  logic             retry_fire;
  logic             abort_now;
  logic [Slots-1:0] free_mask;
  cnt_t             count [Slots];
  DataType          data_table [Slots];

  retry_id_pool #(.IdSize(IDSize)) u_pool (
    .clk         (clk_i),
    .rst         (rst_i),
    .alloc       (alloc_fire),
    .alloc_id    (lowest_free),
    .free_mask   (free_mask),
    .lowest_free (lowest_free),
    .any_free    (any_free),
    .in_flight   (in_flight_o)
  );

  assign exhausted = (count[retry_id_i] == CntMax);

  // A pending retry owns the issue port outright, even when it turns into an abort.
  always_comb begin
    valid_o       = 1'b0;
    ready_o       = 1'b0;
    retry_ready_o = 1'b0;
    id_o          = lowest_free;
    data_o        = data_i;
    alloc_fire    = 1'b0;
    retry_fire    = 1'b0;
    abort_now     = 1'b0;
    if (!rst_i) begin
      if (retry_valid_i) begin
        if (exhausted) begin
          retry_ready_o = 1'b1;
          abort_now     = 1'b1;
        end else begin
          valid_o       = 1'b1;
          id_o          = retry_id_i;
          data_o        = data_table[retry_id_i];
          retry_ready_o = ready_i;
          retry_fire    = ready_i;
        end
      end else begin
        valid_o    = valid_i & any_free;
        ready_o    = ready_i & any_free;
        alloc_fire = valid_i & ready_i & any_free;
      end
    end
  end

  always_comb begin
    free_mask = '0;
    if (!rst_i) begin
      if (done_valid_i) free_mask[done_id_i] = 1'b1;
      if (abort_now)    free_mask[retry_id_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Slots; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < Slots; i++) begin
        if (alloc_fire && lowest_free == id_t'(i)) begin
          count[i] <= '0;
        end else if (free_mask[i]) begin
          count[i] <= '0;
        end else if (retry_fire && retry_id_i == id_t'(i)) begin
          count[i] <= count[i] + cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      abort_valid_o <= 1'b0;
      abort_id_o    <= '0;
    end else begin
      abort_valid_o <= abort_now;
      if (abort_now) abort_id_o <= retry_id_i;
    end
  end

  // Payload storage is never reset; an entry is only read after its allocation wrote it.
  always_ff @(posedge clk_i) begin
    if (alloc_fire) data_table[lowest_free] <= data_i;
  end

endmodule

// File: tb/tb_retry_scheduler.sv
// Directed scenarios with literal expectations, then randomized traffic against a slot-table model.
module tb_retry_scheduler;

  localparam int MAXR = 3;

  logic       clk;
  logic       rst_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic [1:0] id_o;
  logic       valid_o;
  logic       ready_i;
  logic [1:0] retry_id_i;
  logic       retry_valid_i;
  logic       retry_ready_o;
  logic [1:0] done_id_i;
  logic       done_valid_i;
  logic [1:0] abort_id_o;
  logic       abort_valid_o;
  logic [2:0] in_flight_o;

  int n_tests = 0;
  int n_fail  = 0;

  retry_scheduler #(
    .DataType   (logic [7:0]),
    .IDSize     (2),
    .MaxRetries (MAXR)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .data_o        (data_o),
    .id_o          (id_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .retry_id_i    (retry_id_i),
    .retry_valid_i (retry_valid_i),
    .retry_ready_o (retry_ready_o),
    .done_id_i     (done_id_i),
    .done_valid_i  (done_valid_i),
    .abort_id_o    (abort_id_o),
    .abort_valid_o (abort_valid_o),
    .in_flight_o   (in_flight_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: one entry per ID slot
  bit         m_alloc [4];
  int         m_cnt [4];
  logic [7:0] m_tab [4];
  bit         m_abort_v;
  logic [1:0] m_abort_id;
  bit         model_valid = 1'b0;

  always @(negedge clk) begin
    bit         e_valid, e_ready, e_rr, any, pre [4];
    logic [1:0] e_id;
    logic [7:0] e_data;
    int         f, occ;
    f = 0; any = 1'b0;
    for (int i = 3; i >= 0; i--) if (!m_alloc[i]) begin f = i; any = 1'b1; end
    occ = 0;
    for (int i = 0; i < 4; i++) occ += int'(m_alloc[i]);
    e_valid = 1'b0; e_ready = 1'b0; e_rr = 1'b0; e_id = 2'(f); e_data = data_i;
    if (!rst_i) begin
      if (retry_valid_i) begin
        if (m_cnt[retry_id_i] >= MAXR) e_rr = 1'b1;
        else begin
          e_valid = 1'b1; e_id = retry_id_i; e_data = m_tab[retry_id_i]; e_rr = ready_i;
        end
      end else begin
        e_valid = valid_i && any;
        e_ready = ready_i && any;
      end
    end
    if (model_valid) begin
      chk("m_valid_o", valid_o, e_valid);
      chk("m_ready_o", ready_o, e_ready);
      chk("m_retry_ready_o", retry_ready_o, e_rr);
      chk("m_abort_valid_o", abort_valid_o, m_abort_v);
      chk("m_abort_id_o", abort_id_o, m_abort_id);
      chk("m_in_flight_o", in_flight_o, occ);
      if (e_valid) begin
        chk("m_id_o", id_o, e_id);
        chk("m_data_o", data_o, e_data);
      end
    end
    // advance model to the state after the coming rising edge
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin m_alloc[i] = 1'b0; m_cnt[i] = 0; end
      m_abort_v = 1'b0; m_abort_id = 2'd0;
      model_valid = 1'b1;
    end else begin
      pre = m_alloc;
      m_abort_v = 1'b0;
      if (retry_valid_i) begin
        if (m_cnt[retry_id_i] >= MAXR) begin
          m_alloc[retry_id_i] = 1'b0; m_cnt[retry_id_i] = 0;
          m_abort_v = 1'b1; m_abort_id = retry_id_i;
        end else if (ready_i) m_cnt[retry_id_i]++;
      end else if (valid_i && ready_i && any) begin
        m_alloc[f] = 1'b1; m_tab[f] = data_i; m_cnt[f] = 0;
      end
      if (done_valid_i && pre[done_id_i]) begin
        m_alloc[done_id_i] = 1'b0; m_cnt[done_id_i] = 0;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int q[$];
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
    retry_valid_i = 1'b0; retry_id_i = '0; done_valid_i = 1'b0; done_id_i = '0;
    repeat (2) @(posedge clk);
    #1;
    smp();
    chk("rst_ready_o", ready_o, 0);
    chk("rst_in_flight", in_flight_o, 0);
    chk("rst_abort_valid", abort_valid_o, 0);
    tick();
    rst_i = 1'b0;

    // fill all four IDs
    for (int k = 0; k < 4; k++) begin
      valid_i = 1'b1; data_i = 8'hA0 + 8'(k);
      smp();
      chk("fill_id", id_o, k);
      chk("fill_ready", ready_o, 1);
      tick();
    end
    smp();
    chk("full_ready", ready_o, 0);
    chk("full_valid", valid_o, 0);
    chk("full_in_flight", in_flight_o, 4);
    tick();
    valid_i = 1'b0;

    // ID 1 retried to exhaustion
    retry_valid_i = 1'b1; retry_id_i = 2'd1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("retry1_id", id_o, 1);
      chk("retry1_data", data_o, 8'hA1);
      chk("retry1_rr", retry_ready_o, 1);
      chk("retry1_ready_o", ready_o, 0);
      tick();
    end
    smp();
    chk("exhaust1_rr", retry_ready_o, 1);
    chk("exhaust1_valid", valid_o, 0);
    tick();
    retry_valid_i = 1'b0;
    smp();
    chk("abort1_valid", abort_valid_o, 1);
    chk("abort1_id", abort_id_o, 1);
    chk("abort1_in_flight", in_flight_o, 3);
    tick();
    smp();
    chk("abort1_pulse_end", abort_valid_o, 0);
    tick();

    // retry beats a simultaneous new op
    valid_i = 1'b1; data_i = 8'h55; retry_valid_i = 1'b1; retry_id_i = 2'd2;
    smp();
    chk("prio_id", id_o, 2);
    chk("prio_data", data_o, 8'hA2);
    chk("prio_ready_o", ready_o, 0);
    tick();
    retry_valid_i = 1'b0;
    smp();
    chk("prio_new_id", id_o, 1);
    chk("prio_new_ready", ready_o, 1);
    chk("prio_new_data", data_o, 8'h55);
    tick();
    valid_i = 1'b0;

    // done while full: ID 0 reusable only from the next cycle
    done_valid_i = 1'b1; done_id_i = 2'd0; valid_i = 1'b1; data_i = 8'h66;
    smp();
    chk("done_full_ready", ready_o, 0);
    chk("done_full_valid", valid_o, 0);
    tick();
    done_valid_i = 1'b0;
    smp();
    chk("realloc_ready", ready_o, 1);
    chk("realloc_id", id_o, 0);
    tick();
    valid_i = 1'b0;
    smp();
    chk("realloc_in_flight", in_flight_o, 4);
    tick();

    // backpressured retry holds, counter only moves on handshake
    retry_valid_i = 1'b1; retry_id_i = 2'd3; ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("stall_valid", valid_o, 1);
      chk("stall_id", id_o, 3);
      chk("stall_data", data_o, 8'hA3);
      chk("stall_rr", retry_ready_o, 0);
      tick();
    end
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("stall_issue_valid", valid_o, 1);
      chk("stall_issue_rr", retry_ready_o, 1);
      tick();
    end
    smp();
    chk("exhaust3_rr", retry_ready_o, 1);
    chk("exhaust3_valid", valid_o, 0);
    tick();
    retry_valid_i = 1'b0;
    smp();
    chk("abort3_valid", abort_valid_o, 1);
    chk("abort3_id", abort_id_o, 3);
    chk("abort3_in_flight", in_flight_o, 3);
    tick();

    // reset with three IDs in flight
    rst_i = 1'b1; valid_i = 1'b1; data_i = 8'h77; retry_valid_i = 1'b1; retry_id_i = 2'd0;
    smp();
    chk("midrst_ready", ready_o, 0);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_rr", retry_ready_o, 0);
    tick();
    rst_i = 1'b0; retry_valid_i = 1'b0;
    smp();
    chk("postrst_in_flight", in_flight_o, 0);
    chk("postrst_abort", abort_valid_o, 0);
    chk("postrst_id", id_o, 0);
    chk("postrst_ready", ready_o, 1);
    tick();
    valid_i = 1'b0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_i   = ($urandom_range(0, 299) == 0);
      valid_i = ($urandom_range(0, 1) == 1);
      ready_i = ($urandom_range(0, 3) != 0);
      data_i  = 8'($urandom_range(0, 255));
      q.delete();
      for (int i = 0; i < 4; i++) if (m_alloc[i]) q.push_back(i);
      retry_valid_i = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      retry_id_i    = (q.size() > 0) ? 2'(q[$urandom_range(0, q.size() - 1)]) : 2'd0;
      done_valid_i  = ($urandom_range(0, 4) == 0);
      done_id_i     = 2'($urandom_range(0, 3));
      tick();
    end
    rst_i = 1'b0; valid_i = 1'b0; retry_valid_i = 1'b0; done_valid_i = 1'b0;
    smp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
